// File: rtl/rsa_job_ctrl_if.sv
// rsa_job_ctrl_if: job request, core launch and result FIFO signals of the RSA job controller
// slave  : controller side (accepts jobs, drives the core, sources results)
// master : environment side (issues jobs, plays the core, drains results)
interface rsa_job_ctrl_if #(
    parameter int base_width = 6,
    parameter int expo_width = 6,
    parameter int N_width    = 6,
    parameter int TAG_W      = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [base_width-1:0] in_base;
    logic [expo_width-1:0] in_expo;
    logic [N_width-1:0]    in_N;
    logic [TAG_W-1:0]      in_tag;
    logic                  core_start;
    logic [base_width-1:0] core_base;
    logic [expo_width-1:0] core_expo;
    logic [N_width-1:0]    core_N;
    logic [N_width-1:0]    core_result;
    logic                  core_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_width-1:0]    out_result;
    logic [TAG_W-1:0]      out_tag;
    logic                  out_err;
    logic                  busy;

    modport slave (
        input  in_valid, in_base, in_expo, in_N, in_tag, core_result, core_valid, out_ready,
        output in_ready, core_start, core_base, core_expo, core_N, out_valid, out_result, out_tag, out_err, busy
    );

    modport master (
        output in_valid, in_base, in_expo, in_N, in_tag, core_result, core_valid, out_ready,
        input  in_ready, core_start, core_base, core_expo, core_N, out_valid, out_result, out_tag, out_err, busy
    );
endinterface

// File: rtl/rsa_job_ctrl.sv
// rsa_job_ctrl: launches (base, expo, N, tag) jobs one at a time on the modexp core and queues tagged results
// clk, rst : rising-edge clock, asynchronous active-high reset
// bus      : in_* job handshake, core_* launch/result, out_* FWFT result FIFO, busy
module rsa_job_ctrl #(
    parameter int base_width = 6,
    parameter int expo_width = 6,
    parameter int N_width    = 6,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 80
) (
    input  logic           clk,
    input  logic           rst,
    rsa_job_ctrl_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, START, ARM, WAIT, PUSH} state_t;

    state_t                state, nxt;
    logic [base_width-1:0] base_q;
    logic [expo_width-1:0] expo_q;
    logic [N_width-1:0]    n_q, res_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  err_q;
    logic [TW-1:0]         tmo;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [N_width-1:0]    mem_res [FIFO_DEPTH];
    logic [TAG_W-1:0]      mem_tag [FIFO_DEPTH];
    logic                  mem_err [FIFO_DEPTH];
    logic                  accept, expired, push, pop;

    // in_ready is forced low during reset even though state/count already read IDLE/empty
    assign bus.in_ready   = !rst && state == IDLE && count < CW'(FIFO_DEPTH);
    assign accept         = bus.in_valid && bus.in_ready;
    assign expired        = state == WAIT && !bus.core_valid && tmo == TW'(TIMEOUT - 1);
    assign push           = state == PUSH;
    assign pop            = bus.out_valid && bus.out_ready;
    assign bus.busy       = state != IDLE;
    assign bus.core_base  = base_q;
    assign bus.core_expo  = expo_q;
    assign bus.core_N     = n_q;
    assign bus.out_valid  = count != '0;
    assign bus.out_result = mem_res[rd_ptr];
    assign bus.out_tag    = mem_tag[rd_ptr];
    assign bus.out_err    = mem_err[rd_ptr];

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    // ARM exists only to skip a core_valid possibly still high from the previous job
    always_comb begin
        nxt            = state;
        bus.core_start = 1'b0;
        case (state)
            IDLE:    if (accept) nxt = bus.in_N == '0 ? PUSH : START;
            START:   begin bus.core_start = 1'b1; nxt = ARM; end
            ARM:     nxt = WAIT;
            WAIT:    if (bus.core_valid || expired) nxt = PUSH;
            PUSH:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // core_valid is checked before the timeout so a result on the last cycle still counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            expo_q <= '0;
            n_q    <= '0;
            tag_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            tmo    <= '0;
        end else begin
            if (accept) begin
                base_q <= bus.in_base;
                expo_q <= bus.in_expo;
                n_q    <= bus.in_N;
                tag_q  <= bus.in_tag;
                res_q  <= '0;
                err_q  <= bus.in_N == '0;
            end
            if (state == ARM) tmo <= '0;
            if (state == WAIT) begin
                if (bus.core_valid) begin
                    res_q <= bus.core_result;
                    err_q <= 1'b0;
                end else if (expired) begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end
        end
    end

    // a slot is always free on push: acceptance required count < FIFO_DEPTH and only one job is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) begin
            mem_res[wr_ptr] <= res_q;
            mem_tag[wr_ptr] <= tag_q;
            mem_err[wr_ptr] <= err_q;
        end
endmodule

// File: tb/tb_rsa_job_ctrl.sv
// tb_rsa_job_ctrl: directed checks of rsa_job_ctrl against a behavioural modexp core
module tb_rsa_job_ctrl;
    localparam int TIMEOUT = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rsa_job_ctrl_if bus ();
    rsa_job_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int vec = 0;
    int bad = 0;
    int starts = 0;

    // core model: result expo+2 cycles after start; valid stays high until two edges after the next start
    logic       m_valid = 1'b0;
    logic [5:0] m_res = '0;
    logic [5:0] m_next = '0;
    int         m_cnt = 0;
    logic       hang = 1'b0;
    logic       force_v = 1'b0;
    logic [5:0] force_res = '0;

    assign bus.core_valid  = force_v | (m_valid & ~hang);
    assign bus.core_result = force_v ? force_res : m_res;

    function automatic logic [5:0] modexp(input logic [5:0] b, input logic [5:0] e, input logic [5:0] n);
        int r;
        r = 1 % int'(n);
        for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(n);
        return 6'(r);
    endfunction

    always @(posedge clk) begin
        if (bus.core_start) begin
            starts <= starts + 1;
            m_cnt  <= int'(bus.core_expo) + 2;
            m_next <= modexp(bus.core_base, bus.core_expo, bus.core_N);
        end else if (m_cnt > 1) begin
            m_valid <= 1'b0;
            m_cnt   <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_valid <= 1'b1;
            m_res   <= m_next;
            m_cnt   <= 0;
        end
    end

    task automatic send(input logic [5:0] b, input logic [5:0] e, input logic [5:0] n, input logic [3:0] t, output bit ok);
        @(negedge clk);
        bus.in_base  = b;
        bus.in_expo  = e;
        bus.in_N     = n;
        bus.in_tag   = t;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++;
        if ({bus.out_valid, bus.busy, bus.in_ready, bus.core_start} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got valid/busy/ready/start=%b want 0000", {bus.out_valid, bus.busy, bus.in_ready, bus.core_start});
        end
        vec++;
        if ({bus.core_base, bus.core_expo, bus.core_N} !== 18'd0) begin
            bad++;
            $display("FAIL reset_operands: got %0d/%0d/%0d want 0/0/0", bus.core_base, bus.core_expo, bus.core_N);
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({bus.in_ready, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: got ready/busy=%b want 10", {bus.in_ready, bus.busy});
        end
    endtask

    task automatic test_basic();
        bit ok, okv;
        int s0;
        bus.out_ready = 1'b1;
        s0 = starts;
        send(6'd5, 6'd3, 6'd13, 4'd2, ok);
        vec++;
        if (!ok || bus.core_start !== 1'b1 || {bus.core_base, bus.core_expo, bus.core_N} !== {6'd5, 6'd3, 6'd13}) begin
            bad++;
            $display("FAIL basic_start: got ok=%0d start=%b ops=%0d/%0d/%0d want 1 1 5/3/13", ok, bus.core_start, bus.core_base, bus.core_expo, bus.core_N);
        end
        @(negedge clk);
        vec++;
        if (bus.core_start !== 1'b0) begin
            bad++;
            $display("FAIL basic_start_pulse: got start=%b in ARM want 0", bus.core_start);
        end
        wait_valid(okv);
        vec++;
        if (!okv || {bus.out_result, bus.out_tag, bus.out_err} !== {6'd8, 4'd2, 1'b0}) begin
            bad++;
            $display("FAIL basic_entry: got ok=%0d res=%0d tag=%0d err=%b want 8/2/0", okv, bus.out_result, bus.out_tag, bus.out_err);
        end
        @(negedge clk);
        vec++;
        if (bus.out_valid !== 1'b0 || starts - s0 != 1) begin
            bad++;
            $display("FAIL basic_single: got valid=%b starts=%0d want 0 and 1", bus.out_valid, starts - s0);
        end
    endtask

    task automatic test_edge_expo();
        bit ok, okv;
        send(6'd1, 6'd0, 6'd1, 4'd1, ok);
        wait_valid(okv);
        vec++;
        if (!ok || !okv || {bus.out_result, bus.out_tag, bus.out_err} !== {6'd0, 4'd1, 1'b0}) begin
            bad++;
            $display("FAIL expo0_n1: got ok=%0d/%0d res=%0d tag=%0d err=%b want 0/1/0", ok, okv, bus.out_result, bus.out_tag, bus.out_err);
        end
        @(negedge clk);
        send(6'd4, 6'd0, 6'd7, 4'd3, ok);
        wait_valid(okv);
        vec++;
        if (!ok || !okv || {bus.out_result, bus.out_tag, bus.out_err} !== {6'd1, 4'd3, 1'b0}) begin
            bad++;
            $display("FAIL expo0_stale: got ok=%0d/%0d res=%0d tag=%0d err=%b want 1/3/0", ok, okv, bus.out_result, bus.out_tag, bus.out_err);
        end
        @(negedge clk);
        vec++;
        if (bus.busy !== 1'b0 || {bus.core_base, bus.core_expo, bus.core_N} !== {6'd4, 6'd0, 6'd7}) begin
            bad++;
            $display("FAIL idle_operands: got busy=%b ops=%0d/%0d/%0d want 0 4/0/7", bus.busy, bus.core_base, bus.core_expo, bus.core_N);
        end
    endtask

    task automatic test_zero_mod();
        bit ok;
        int s0;
        bus.out_ready = 1'b0;
        s0 = starts;
        send(6'd9, 6'd9, 6'd0, 4'd5, ok);
        vec++;
        if (!ok || bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.core_start !== 1'b0) begin
            bad++;
            $display("FAIL zero_push_cycle: got ok=%0d valid=%b busy=%b start=%b want 1 0 1 0", ok, bus.out_valid, bus.busy, bus.core_start);
        end
        repeat (2) @(negedge clk);
        vec++;
        if (bus.out_valid !== 1'b1 || {bus.out_result, bus.out_tag, bus.out_err} !== {6'd0, 4'd5, 1'b1}) begin
            bad++;
            $display("FAIL zero_entry: got valid=%b res=%0d tag=%0d err=%b want 1 0/5/1", bus.out_valid, bus.out_result, bus.out_tag, bus.out_err);
        end
        vec++;
        if (starts != s0) begin
            bad++;
            $display("FAIL zero_no_start: got %0d core starts want 0", starts - s0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        vec++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_pop: got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit ok, ok5, okv, okb;
        logic [5:0] er [5];
        er[0] = 6'd2; er[1] = 6'd4; er[2] = 6'd8; er[3] = 6'd5; er[4] = 6'd10;
        bus.out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            send(6'd2, 6'(t + 1), 6'd11, 4'(t), ok);
            vec++;
            if (!ok) begin
                bad++;
                $display("FAIL bp_accept: job %0d not accepted got ok=0 want 1", t);
            end
        end
        okb = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) begin
                okb = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_base  = 6'd2;
        bus.in_expo  = 6'd5;
        bus.in_N     = 6'd11;
        bus.in_tag   = 4'd4;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vec++;
            if (!okb || {bus.in_ready, bus.busy, bus.out_valid} !== 3'b001) begin
                bad++;
                $display("FAIL bp_full: got idle=%0d ready/busy/valid=%b want 1 001", okb, {bus.in_ready, bus.busy, bus.out_valid});
            end
        end
        bus.out_ready = 1'b1;
        fork
            send(6'd2, 6'd5, 6'd11, 4'd4, ok5);
            for (int k = 0; k < 5; k++) begin
                wait_valid(okv);
                vec++;
                if (!okv || {bus.out_result, bus.out_tag, bus.out_err} !== {er[k], 4'(k), 1'b0}) begin
                    bad++;
                    $display("FAIL bp_order: pop %0d got ok=%0d res=%0d tag=%0d err=%b want %0d/%0d/0", k, okv, bus.out_result, bus.out_tag, bus.out_err, er[k], k);
                end
                @(negedge clk);
            end
        join
        vec++;
        if (!ok5 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: got ok5=%0d valid=%b want 1 0", ok5, bus.out_valid);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bus.out_ready = 1'b1;
        hang = 1'b1;
        send(6'd3, 6'd3, 6'd5, 4'd7, ok);
        repeat (2 + TIMEOUT) @(negedge clk);
        vec++;
        if (!ok || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_push_cycle: got ok=%0d valid=%b busy=%b want 1 0 1", ok, bus.out_valid, bus.busy);
        end
        @(negedge clk);
        vec++;
        if (bus.out_valid !== 1'b1 || {bus.out_result, bus.out_tag, bus.out_err} !== {6'd0, 4'd7, 1'b1}) begin
            bad++;
            $display("FAIL timeout_entry: got valid=%b res=%0d tag=%0d err=%b want 1 0/7/1", bus.out_valid, bus.out_result, bus.out_tag, bus.out_err);
        end
        @(negedge clk);
        send(6'd3, 6'd3, 6'd5, 4'd8, ok);
        repeat (2 + TIMEOUT - 1) @(negedge clk);
        force_v   = 1'b1;
        force_res = 6'd6;
        @(negedge clk);
        force_v = 1'b0;
        vec++;
        if (!ok || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL late_push_cycle: got ok=%0d valid=%b busy=%b want 1 0 1", ok, bus.out_valid, bus.busy);
        end
        @(negedge clk);
        vec++;
        if (bus.out_valid !== 1'b1 || {bus.out_result, bus.out_tag, bus.out_err} !== {6'd6, 4'd8, 1'b0}) begin
            bad++;
            $display("FAIL late_valid_wins: got valid=%b res=%0d tag=%0d err=%b want 1 6/8/0", bus.out_valid, bus.out_result, bus.out_tag, bus.out_err);
        end
        @(negedge clk);
        hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok, okv;
        bus.out_ready = 1'b0;
        hang = 1'b1;
        send(6'd2, 6'd5, 6'd9, 4'd9, ok);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if (!ok || {bus.busy, bus.out_valid, bus.in_ready} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid_async: got ok=%0d busy/valid/ready=%b want 1 000", ok, {bus.busy, bus.out_valid, bus.in_ready});
        end
        @(negedge clk);
        rst       = 1'b0;
        force_v   = 1'b1;
        force_res = 6'd3;
        repeat (3) begin
            @(negedge clk);
            vec++;
            if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b001) begin
                bad++;
                $display("FAIL rst_mid_ignore: got busy/valid/ready=%b want 001", {bus.busy, bus.out_valid, bus.in_ready});
            end
        end
        force_v = 1'b0;
        hang    = 1'b0;
        bus.out_ready = 1'b1;
        send(6'd3, 6'd4, 6'd7, 4'd10, ok);
        wait_valid(okv);
        vec++;
        if (!ok || !okv || {bus.out_result, bus.out_tag, bus.out_err} !== {6'd4, 4'd10, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_next: got ok=%0d/%0d res=%0d tag=%0d err=%b want 4/10/0", ok, okv, bus.out_result, bus.out_tag, bus.out_err);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_base   = '0;
        bus.in_expo   = '0;
        bus.in_N      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_edge_expo();
        test_zero_mod();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
